bias_buffer_bank: RTL and testbench

Parametrised successor to the per-layer bias buffers. Captures a serial stream of NB bias words of width WD into a shadow bank. On command, commits the shadow bank to an active bank that drives a flat parallel bias bus to the conv/FC accumulator array. Adds explicit load framing, completion/overflow status and double buffering, so the next layer's biases can load while the current layer computes.

---
 rtl/bias_buffer_bank.sv | 138 +++++++++++++
 tb/tb_bias_buffer_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bias_buffer_bank.sv
// Serial bias capture into a shadow bank, committed on request to a flat parallel active bias bus.
// Define BIAS_BUF_DBUF_EN for double buffering; otherwise words land directly in the active bank.
module bias_buffer_bank #(
  parameter int WD     = 8,
  parameter int NB     = 16,
  parameter int IN_DLY = 2
) (
  input  logic               i_sclk,
  input  logic               i_rstn,
  input  logic [WD-1:0]      i_bias_data,
  input  logic               i_bias_en,
  input  logic               i_load_start,
  input  logic               i_swap,
  output logic [NB*WD-1:0]   o_bias,
  output logic               o_valid,
  output logic               o_load_done,
  output logic               o_overflow
);

  localparam int PW = $clog2(NB + 1);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [WD-1:0] d_data;
  logic          d_en;
  logic          d_start;

  generate
    if (IN_DLY == 0) begin : g_nodly
      assign d_data  = i_bias_data;
      assign d_en    = i_bias_en;
      assign d_start = i_load_start;
    end else begin : g_dly
      logic [WD-1:0] data_p  [IN_DLY];
      logic          vld_p   [IN_DLY];
      logic          start_p [IN_DLY];

      always_ff @(posedge i_sclk) begin
        if (!i_rstn) begin
          for (int i = 0; i < IN_DLY; i++) begin
            data_p[i]  <= '0;
            vld_p[i]   <= 1'b0;
            start_p[i] <= 1'b0;
          end
        end else begin
          data_p[0]  <= i_bias_data;
          vld_p[0]   <= i_bias_en;
          start_p[0] <= i_load_start;
          for (int i = 1; i < IN_DLY; i++) begin
            data_p[i]  <= data_p[i-1];
            vld_p[i]   <= vld_p[i-1];
            start_p[i] <= start_p[i-1];
          end
        end
      end

      assign d_data  = data_p[IN_DLY-1];
      assign d_en    = vld_p[IN_DLY-1];
      assign d_start = start_p[IN_DLY-1];
    end
  endgenerate

  // A start opens the frame in the same cycle, so a coincident word goes to slot 0.
  logic [IW-1:0] wr_idx;
  logic          do_wr;
  logic          last_wr;
  logic          dropped;

  always_comb begin
    wr_idx  = d_start ? '0 : wr_ptr[IW-1:0];
    do_wr   = d_en && (d_start || (state == LOAD));
    last_wr = d_start ? (NB == 1) : (wr_ptr == PW'(NB - 1));
    dropped = d_en && !d_start && (state != LOAD);
  end

`ifdef BIAS_BUF_DBUF_EN
  logic [NB*WD-1:0] shadow;
`else
  logic unused_swap;
  assign unused_swap = i_swap;
`endif

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      o_bias      <= '0;
      o_valid     <= 1'b0;
      o_load_done <= 1'b0;
      o_overflow  <= 1'b0;
`ifdef BIAS_BUF_DBUF_EN
      shadow      <= '0;
`endif
    end else begin
      if (d_start) begin
        state       <= LOAD;
        wr_ptr      <= '0;
        o_load_done <= 1'b0;
        o_overflow  <= 1'b0;
      end else if (dropped) begin
        o_overflow  <= 1'b1;
      end

`ifdef BIAS_BUF_DBUF_EN
      // Swap reads the bank as it stood before this edge's write.
      if ((state == FULL) && i_swap) begin
        o_bias      <= shadow;
        o_valid     <= 1'b1;
        o_load_done <= 1'b0;
        if (!d_start)
          state <= IDLE;
      end
      if (do_wr)
        shadow[int'(wr_idx)*WD +: WD] <= d_data;
`else
      if (d_start)
        o_valid <= 1'b0;
      if (do_wr)
        o_bias[int'(wr_idx)*WD +: WD] <= d_data;
`endif

      if (do_wr) begin
        wr_ptr <= (d_start ? '0 : wr_ptr) + PW'(1);
        if (last_wr) begin
          state       <= FULL;
          o_load_done <= 1'b1;
`ifndef BIAS_BUF_DBUF_EN
          o_valid     <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_bias_buffer_bank.sv
// Directed bench for bias_buffer_bank: NB=16/IN_DLY=2 and NB=4/IN_DLY=0 instances share stimulus.
module tb_bias_buffer_bank;

`ifdef BIAS_BUF_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  localparam logic [127:0] Z = '0;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [7:0]   data = '0;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic         swap = 1'b0;

  logic [127:0] bias_a;
  logic         valid_a, done_a, ovf_a;
  logic [31:0]  bias_b;
  logic         valid_b, done_b, ovf_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bias_buffer_bank #(.WD(8), .NB(16), .IN_DLY(2)) dut_a (
    .i_sclk(clk), .i_rstn(rstn), .i_bias_data(data), .i_bias_en(en),
    .i_load_start(start), .i_swap(swap),
    .o_bias(bias_a), .o_valid(valid_a), .o_load_done(done_a), .o_overflow(ovf_a)
  );

  bias_buffer_bank #(.WD(8), .NB(4), .IN_DLY(0)) dut_b (
    .i_sclk(clk), .i_rstn(rstn), .i_bias_data(data), .i_bias_en(en),
    .i_load_start(start), .i_swap(swap),
    .o_bias(bias_b), .o_valid(valid_b), .o_load_done(done_b), .o_overflow(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [7:0] d);
    en   = 1'b1;
    data = d;
    tick();
    en   = 1'b0;
  endtask

  task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Word k (k < cnt) = base + k, remaining words zero.
  function automatic logic [127:0] ramp(input int base, input int cnt);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < cnt; k++)
      v[k*8 +: 8] = 8'(base + k);
    return v;
  endfunction

  function automatic logic [127:0] vb(input logic [31:0] b);
    return {96'b0, b};
  endfunction

  logic [127:0] mix;

  initial begin
    // Reset state
    rstn = 1'b0;
    tick();
    tick();
    chkv("rst_bias_a", bias_a, Z);
    chkb("rst_valid_a", valid_a, 1'b0);
    chkb("rst_done_a", done_a, 1'b0);
    chkb("rst_ovf_a", ovf_a, 1'b0);
    chkv("rst_bias_b", vb(bias_b), Z);
    chkb("rst_valid_b", valid_b, 1'b0);
    rstn = 1'b1;
    tick();

    // Frame 1: start pulse then 0x01..0x10
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) word(8'(k + 1));
    chkv("f1_lat14_bias_a", bias_a, DBUF ? Z : ramp(1, 14));
    chkb("f1_lat14_done_a", done_a, 1'b0);
    tick();
    chkv("f1_lat15_bias_a", bias_a, DBUF ? Z : ramp(1, 15));
    chkb("f1_lat15_done_a", done_a, 1'b0);
    tick();
    chkb("f1_done_a", done_a, 1'b1);
    chkb("f1_valid_a", valid_a, !DBUF);
    chkv("f1_bias_a", bias_a, DBUF ? Z : ramp(1, 16));
    chkb("f1_ovf_a", ovf_a, 1'b0);
    chkv("f1_bias_b", vb(bias_b), DBUF ? Z : ramp(1, 4));
    chkb("f1_done_b", done_b, 1'b1);
    chkb("f1_ovf_b", ovf_b, 1'b1);
    chkb("f1_valid_b", valid_b, !DBUF);

    swap = 1'b1;
    tick();
    swap = 1'b0;
    chkv("sw1_bias_a", bias_a, ramp(1, 16));
    chkb("sw1_valid_a", valid_a, 1'b1);
    chkb("sw1_done_a", done_a, !DBUF);
    chkv("sw1_bias_b", vb(bias_b), ramp(1, 4));
    chkb("sw1_valid_b", valid_b, 1'b1);

    // Frame 2: start coincident with first word, 0xA0..0xAF
    start = 1'b1;
    word(8'hA0);
    start = 1'b0;
    for (int k = 1; k < 16; k++) word(8'(8'hA0 + k));
    mix = ramp(8'hA0, 14);
    mix[14*8 +: 8] = 8'h0F;
    mix[15*8 +: 8] = 8'h10;
    chkv("f2_mid_bias_a", bias_a, DBUF ? ramp(1, 16) : mix);
    chkb("f2_mid_valid_a", valid_a, DBUF);
    chkb("f2_mid_done_a", done_a, 1'b0);
    tick();
    tick();
    chkv("f2_bias_a", bias_a, DBUF ? ramp(1, 16) : ramp(8'hA0, 16));
    chkb("f2_done_a", done_a, 1'b1);
    chkb("f2_valid_a", valid_a, 1'b1);
    chkv("f2_bias_b", vb(bias_b), DBUF ? ramp(1, 4) : ramp(8'hA0, 4));
    chkb("f2_ovf_b", ovf_b, 1'b1);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chkv("sw2_bias_a", bias_a, ramp(8'hA0, 16));
    chkv("sw2_bias_b", vb(bias_b), ramp(8'hA0, 4));
    chkb("sw2_done_a", done_a, !DBUF);

    // Frame 3: 17 words, the last one overflows
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 17; k++) word(8'(8'h30 + k));
    chkb("f3_ovf_lat0_a", ovf_a, 1'b0);
    tick();
    chkb("f3_ovf_lat1_a", ovf_a, 1'b0);
    tick();
    chkb("f3_ovf_a", ovf_a, 1'b1);
    chkb("f3_done_a", done_a, 1'b1);
    chkv("f3_bias_a", bias_a, DBUF ? ramp(8'hA0, 16) : ramp(8'h30, 16));
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chkv("sw3_bias_a", bias_a, ramp(8'h30, 16));
    chkv("sw3_bias_b", vb(bias_b), ramp(8'h30, 4));
    chkb("sw3_ovf_b", ovf_b, 1'b1);

    // Fresh start clears overflow; active bank held
    start = 1'b1;
    tick();
    start = 1'b0;
    chkb("st_ovf_b", ovf_b, 1'b0);
    chkb("st_valid_b", valid_b, DBUF);
    tick();
    tick();
    chkb("st_ovf_a", ovf_a, 1'b0);
    chkb("st_done_a", done_a, 1'b0);
    chkb("st_valid_a", valid_a, DBUF);
    chkv("st_bias_a", bias_a, ramp(8'h30, 16));

    // NB=4: swap coincident with final write is ignored, one cycle later commits
    start = 1'b1;
    word(8'd5);
    start = 1'b0;
    word(8'd6);
    word(8'd7);
    chkb("n4_pre_done_b", done_b, 1'b0);
    swap = 1'b1;
    word(8'd8);
    chkb("n4_done_b", done_b, 1'b1);
    chkv("n4_early_bias_b", vb(bias_b), DBUF ? ramp(8'h30, 4) : ramp(5, 4));
    chkb("n4_valid_b", valid_b, 1'b1);
    tick();
    swap = 1'b0;
    chkv("n4_sw_bias_b", vb(bias_b), ramp(5, 4));
    chkb("n4_sw_done_b", done_b, !DBUF);
    tick();
    tick();
    tick();

    // Reset mid-frame with words still in the delay line
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) word(8'(8'h70 + k));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chkv("mr_bias_a", bias_a, Z);
    chkb("mr_valid_a", valid_a, 1'b0);
    chkb("mr_done_a", done_a, 1'b0);
    chkb("mr_ovf_a", ovf_a, 1'b0);
    chkv("mr_bias_b", vb(bias_b), Z);
    chkb("mr_done_b", done_b, 1'b0);
    tick();
    tick();
    tick();
    chkv("mr_flush_bias_a", bias_a, Z);
    chkb("mr_flush_ovf_a", ovf_a, 1'b0);
    word(8'h99);
    chkb("idle_ovf_b", ovf_b, 1'b1);
    chkb("idle_ovf_lat_a", ovf_a, 1'b0);
    tick();
    tick();
    chkb("idle_ovf_a", ovf_a, 1'b1);
    chkv("idle_bias_a", bias_a, Z);
    chkb("idle_valid_a", valid_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
